// File: rtl/response_misr_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | response_misr_checker_if : control/response bus of the MISR checker      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface response_misr_checker_if #(
  parameter int IN_W  = 3,
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] skip_len;
  logic [CNT_W-1:0] window_len;
  logic [SIG_W-1:0] expected;
  logic [IN_W-1:0]  resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, skip_len, window_len, expected, resp_in,
    input  busy, done, pass, signature, cycle_cnt
  );

  modport slave (
    input  start, skip_len, window_len, expected, resp_in,
    output busy, done, pass, signature, cycle_cnt
  );
endinterface
`default_nettype wire

// File: rtl/response_misr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | response_misr_checker : windowed MISR compaction with golden compare      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module response_misr_checker #(
  parameter int               IN_W  = 3,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'hB400,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               CNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  response_misr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             done_entry;
  logic [SIG_W-1:0] misr_next;

  // Galois step: shift, fold the outgoing MSB through POLY, inject the sample
  always_comb begin
    misr_next = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
              ^ {{(SIG_W-IN_W){1'b0}}, bus.resp_in};
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    win_d      = win_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    done_entry = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          skip_cnt_d = bus.skip_len;
          win_d      = bus.window_len;
          exp_d      = bus.expected;
          sig_d      = SEED;
          cnt_d      = '0;
          pass_d     = 1'b0;
          if (bus.skip_len != '0) begin
            state_d = ST_SKIP;
          end else if (bus.window_len != '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d    = ST_DONE;
            done_entry = 1'b1;
          end
        end
      end
      ST_SKIP: begin
        skip_cnt_d = skip_cnt_q - CNT_W'(1);
        if (skip_cnt_q == CNT_W'(1)) begin
          if (win_q != '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d    = ST_DONE;
            done_entry = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        sig_d = misr_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == win_q - CNT_W'(1)) begin
          state_d    = ST_DONE;
          done_entry = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An unknown signature must fail, so X in the compare falls to the else arm
    if (done_entry) begin
      if (sig_d == exp_d) begin
        pass_d = 1'b1;
      end else begin
        pass_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      skip_cnt_q <= '0;
      win_q      <= '0;
      exp_q      <= '0;
      sig_q      <= SEED;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      win_q      <= win_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.busy      = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.cycle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_response_misr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_response_misr_checker : directed bench for response_misr_checker      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_response_misr_checker;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  response_misr_checker_if #(.IN_W(3), .SIG_W(16), .CNT_W(16)) bus ();

  response_misr_checker #(
    .IN_W (3),
    .SIG_W(16),
    .POLY (16'hB400),
    .SEED (16'hFFFF),
    .CNT_W(16)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] skip, input logic [15:0] win,
                        input logic [15:0] exp, input logic [2:0] resp);
    bus.skip_len   = skip;
    bus.window_len = win;
    bus.expected   = exp;
    bus.resp_in    = resp;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.skip_len   = '0;
    bus.window_len = '0;
    bus.expected   = '0;
    bus.resp_in    = '0;

    // Reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_sig",  32'(bus.signature), 32'hFFFF);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_pass", 32'(bus.pass), 32'd0);
    check_val("rst_cnt",  32'(bus.cycle_cnt), 32'd0);

    // Single sample: FFFF -> 4BFE ^ 5 = 4BFB
    launch(16'd0, 16'd1, 16'h4BFB, 3'b101);
    check_val("s1_busy", 32'(bus.busy), 32'd1);
    check_val("s1_done0", 32'(bus.done), 32'd0);
    tick();
    check_val("s1_done", 32'(bus.done), 32'd1);
    check_val("s1_busy0", 32'(bus.busy), 32'd0);
    check_val("s1_sig", 32'(bus.signature), 32'h4BFB);
    check_val("s1_cnt", 32'(bus.cycle_cnt), 32'd1);
    check_val("s1_pass", 32'(bus.pass), 32'd1);

    // Skip 2 with noisy responses, then two zero samples: FFFF -> 4BFE -> 97FC
    launch(16'd2, 16'd2, 16'h97FC, 3'b111);
    check_val("s2_done_clr", 32'(bus.done), 32'd0);
    check_val("s2_pass_clr", 32'(bus.pass), 32'd0);
    check_val("s2_seed", 32'(bus.signature), 32'hFFFF);
    tick();
    tick();
    check_val("s2_skip_sig", 32'(bus.signature), 32'hFFFF);
    bus.resp_in = 3'b000;
    tick();
    check_val("s2_mid_sig", 32'(bus.signature), 32'h4BFE);
    check_val("s2_mid_cnt", 32'(bus.cycle_cnt), 32'd1);
    check_val("s2_mid_done", 32'(bus.done), 32'd0);
    tick();
    check_val("s2_done", 32'(bus.done), 32'd1);
    check_val("s2_sig", 32'(bus.signature), 32'h97FC);
    check_val("s2_pass", 32'(bus.pass), 32'd1);

    launch(16'd2, 16'd2, 16'h97FD, 3'b111);
    tick();
    tick();
    bus.resp_in = 3'b000;
    tick();
    tick();
    check_val("s2b_done", 32'(bus.done), 32'd1);
    check_val("s2b_sig", 32'(bus.signature), 32'h97FC);
    check_val("s2b_pass", 32'(bus.pass), 32'd0);

    // Zero window
    launch(16'd0, 16'd0, 16'hFFFF, 3'b011);
    check_val("z_done", 32'(bus.done), 32'd1);
    check_val("z_cnt", 32'(bus.cycle_cnt), 32'd0);
    check_val("z_pass", 32'(bus.pass), 32'd1);
    check_val("z_sig", 32'(bus.signature), 32'hFFFF);

    // Skip without window ends after the skip phase
    launch(16'd3, 16'd0, 16'h1234, 3'b000);
    tick();
    tick();
    check_val("sk_busy", 32'(bus.busy), 32'd1);
    tick();
    check_val("sk_done", 32'(bus.done), 32'd1);
    check_val("sk_pass", 32'(bus.pass), 32'd0);

    // Start while busy is ignored: 4 zeros give 4BFE, 97FC, 9BF8, 83F0
    launch(16'd0, 16'd4, 16'h83F0, 3'b000);
    tick();
    bus.start      = 1'b1;
    bus.skip_len   = 16'd5;
    bus.window_len = 16'd9;
    bus.expected   = 16'h0000;
    tick();
    bus.start = 1'b0;
    check_val("sb_busy", 32'(bus.busy), 32'd1);
    check_val("sb_cnt2", 32'(bus.cycle_cnt), 32'd2);
    tick();
    tick();
    check_val("sb_done", 32'(bus.done), 32'd1);
    check_val("sb_cnt", 32'(bus.cycle_cnt), 32'd4);
    check_val("sb_sig", 32'(bus.signature), 32'h83F0);
    check_val("sb_pass", 32'(bus.pass), 32'd1);
    tick();
    check_val("sb_hold_cnt", 32'(bus.cycle_cnt), 32'd4);
    check_val("sb_hold_sig", 32'(bus.signature), 32'h83F0);

    // Restart from DONE
    launch(16'd0, 16'd1, 16'h4BFB, 3'b101);
    check_val("rs_done", 32'(bus.done), 32'd0);
    check_val("rs_pass", 32'(bus.pass), 32'd0);
    check_val("rs_sig", 32'(bus.signature), 32'hFFFF);
    check_val("rs_cnt", 32'(bus.cycle_cnt), 32'd0);
    tick();
    check_val("rs_fin_pass", 32'(bus.pass), 32'd1);

    // Reset mid-capture, asynchronous
    launch(16'd0, 16'd3, 16'h0000, 3'b000);
    tick();
    check_val("mr_cnt1", 32'(bus.cycle_cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mr_sig", 32'(bus.signature), 32'hFFFF);
    check_val("mr_busy", 32'(bus.busy), 32'd0);
    check_val("mr_cnt", 32'(bus.cycle_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_val("mr_nodone", 32'(bus.done), 32'd0);
    check_val("mr_idle", 32'(bus.busy), 32'd0);

    // Fresh run after reset: skip 1, window 1
    launch(16'd1, 16'd1, 16'h4BFB, 3'b000);
    bus.resp_in = 3'b101;
    tick();
    check_val("fr_busy", 32'(bus.busy), 32'd1);
    tick();
    check_val("fr_done", 32'(bus.done), 32'd1);
    check_val("fr_sig", 32'(bus.signature), 32'h4BFB);
    check_val("fr_pass", 32'(bus.pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
